// File: rtl/lfsr_chk_if.sv
// Serial PRBS link bundle between a pattern source and the lfsr_chk receiver.
interface lfsr_chk_if #(
    parameter int unsigned ERR_W = 16
) ();
    logic             din;
    logic             din_valid;
    logic             err_clr;
    logic             locked;
    logic             bit_err;
    logic [ERR_W-1:0] err_cnt;

    // Stream source / test logic side
    modport master (
        output din,
        output din_valid,
        output err_clr,
        input  locked,
        input  bit_err,
        input  err_cnt
    );

    // Checker side
    modport slave (
        input  din,
        input  din_valid,
        input  err_clr,
        output locked,
        output bit_err,
        output err_cnt
    );
endinterface

// File: rtl/lfsr_chk.sv
// Receive-side checker for the 16-bit Galois LFSR pattern generator:
// bit-slips a local LFSR copy into alignment, then flags and counts errors.
module lfsr_chk #(
    parameter logic [15:0] SEED     = 16'hA2C1,
    parameter int unsigned LOCK_CNT = 32,
    parameter int unsigned LOSS_CNT = 8,
    parameter int unsigned ERR_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    lfsr_chk_if.slave   bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic               locked_q;
    logic               bit_err_q, bit_err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               hit;

    // Generator advance function; L7 is deliberately dead and L6 feeds two taps.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        logic [15:0] g;
        g[15]   = l[0];
        g[14:8] = l[15:9];
        g[7]    = l[8] ^ l[0];
        g[6]    = l[6];
        g[5]    = l[6] ^ l[0];
        g[4]    = l[5] ^ l[0];
        g[3]    = l[4] ^ l[0];
        g[2:0]  = l[3:1];
        return g;
    endfunction

    assign hit = (bus.din == lfsr_q[0]);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: lock after LOCK_CNT straight matches, drop after LOSS_CNT straight misses
    always_comb begin
        state_d = state_q;
        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (hit && (match_cnt_q == CNT_W'(LOCK_CNT - 1))) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!hit && (miss_cnt_q == CNT_W'(LOSS_CNT - 1))) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Datapath/output next values: LFSR stepping, counters, error pulse and count
    always_comb begin
        lfsr_d      = lfsr_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        bit_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (hit) begin
                        lfsr_d      = lfsr_adv(lfsr_q);
                        match_cnt_d = (state_d == LOCKED) ? '0 : match_cnt_q + CNT_W'(1);
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    lfsr_d = lfsr_adv(lfsr_q);
                    if (hit) begin
                        miss_cnt_d = '0;
                    end else begin
                        bit_err_d = 1'b1;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (state_d == HUNT) begin
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            endcase
        end
        if (bus.err_clr) begin
            err_cnt_d = '0;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q      <= SEED;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            bit_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= (state_d == LOCKED);
            bit_err_q   <= bit_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.locked  = locked_q;
    assign bus.bit_err = bit_err_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lfsr_chk.sv
// Bench for lfsr_chk: reference generator drives the link, expected outputs
// are queued per driven bit and compared one cycle later.
module tb_lfsr_chk;

    localparam logic [15:0] SEED  = 16'hA2C1;
    localparam int unsigned ERR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lfsr_chk_if #(.ERR_W(ERR_W)) bus ();

    lfsr_chk #(
        .SEED     (SEED),
        .LOCK_CNT (32),
        .LOSS_CNT (8),
        .ERR_W    (ERR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             locked;
        logic             bit_err;
        logic [ERR_W-1:0] err_cnt;
        logic             chk_locked;
    } exp_t;

    typedef struct {
        logic valid;
        logic flip;
        logic clr;
        logic e_locked;
        logic e_bit_err;
        int   e_err;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[$];
    logic [15:0] gen;
    int          cmp_cnt  = 0;
    int          mism_cnt = 0;

    // Generator model written as shift-then-tap form
    function automatic logic [15:0] gen_next(input logic [15:0] s);
        logic [15:0] n;
        logic        fb;
        fb   = s[0];
        n    = {fb, s[15:1]};
        n[6] = s[6];
        n[7] = n[7] ^ fb;
        n[5] = n[5] ^ fb;
        n[4] = n[4] ^ fb;
        n[3] = n[3] ^ fb;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mism_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; flip inverts the generator bit; invalid cycles send noise.
    task automatic drive(input logic v, input logic flip, input logic clr,
                         input logic el, input logic eb, input int ec,
                         input logic chk_l, input string tag);
        exp_t e;
        bus.din_valid = v;
        bus.err_clr   = clr;
        if (v) begin
            bus.din = gen[0] ^ flip;
            gen     = gen_next(gen);
        end else begin
            bus.din = 1'($urandom);
        end
        e.locked     = el;
        e.bit_err    = eb;
        e.err_cnt    = ERR_W'(ec);
        e.chk_locked = chk_l;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (e.chk_locked) check({tag, " locked"}, 32'(bus.locked), 32'(e.locked));
        check({tag, " bit_err"}, 32'(bus.bit_err), 32'(e.bit_err));
        check({tag, " err_cnt"}, 32'(bus.err_cnt), 32'(e.err_cnt));
    endtask

    task automatic do_reset();
        bus.din_valid = 1'b0;
        bus.err_clr   = 1'b0;
        bus.din       = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        check("reset locked",  32'(bus.locked),  32'd0);
        check("reset bit_err", 32'(bus.bit_err), 32'd0);
        check("reset err_cnt", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;
        gen = SEED;
    endtask

    function automatic void add(input logic v, input logic f, input logic c,
                                input logic l, input logic b, input int e);
        vec_t r;
        r.valid = v; r.flip = f; r.clr = c;
        r.e_locked = l; r.e_bit_err = b; r.e_err = e;
        vecs.push_back(r);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  vcount;
        logic got;

        // Corner-case table applied while locked with err_cnt=0
        add(1,1,0, 1,1,1);
        add(1,0,0, 1,0,1);
        add(0,0,0, 1,0,1);
        add(0,1,0, 1,0,1);
        add(1,0,0, 1,0,1);
        add(1,1,1, 1,1,0);
        add(1,0,0, 1,0,0);
        add(1,1,0, 1,1,1);
        add(0,0,1, 1,0,0);
        add(1,0,0, 1,0,0);
        for (int k = 1; k <= 7; k++) add(1,1,0, 1,1,k);
        add(1,0,0, 1,0,7);
        for (int k = 8; k <= 14; k++) add(1,1,0, 1,1,k);
        add(1,0,0, 1,0,14);
        add(1,0,1, 1,0,0);

        // Aligned stream: lock on the 32nd valid bit, never an error
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 1'b0, 1'b0, (i >= 31), 1'b0, 0, 1'b1, "aligned");
        end

        // Generator 5 bits ahead: hunt until lock, then 1000 clean bits
        do_reset();
        repeat (5) gen = gen_next(gen);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, "hunt");
            got = bus.locked;
        end
        check("offset lock reached", 32'(bus.locked), 32'd1);
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, "offset");
        end

        // Table: single error, clear priority, valid gaps, sub-threshold miss bursts
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].flip, vecs[i].clr,
                  vecs[i].e_locked, vecs[i].e_bit_err, vecs[i].e_err, 1'b1,
                  $sformatf("vec%0d", i));
        end

        // Loss of lock on the 8th bad bit, relock after 32 clean bits
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, (k < 8), 1'b1, k, 1'b1, "loss");
        end
        for (int i = 1; i <= 32; i++) begin
            drive(1'b1, 1'b0, 1'b0, (i == 32), 1'b0, 8, 1'b1, "relock");
        end

        // Saturation at 15 with 20 spaced errors, then clear racing an error
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, "clr");
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, (k > 15) ? 15 : k, 1'b1, "sat err");
            repeat (9) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (k > 15) ? 15 : k, 1'b1, "sat gap");
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, "clr vs err");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, "after clr");

        // Alternating valid: lock counts valid bits only
        do_reset();
        vcount = 0;
        for (int i = 0; i < 128; i++) begin
            if ((i % 2) == 0) vcount++;
            drive(((i % 2) == 0), 1'b0, 1'b0, (vcount >= 32), 1'b0, 0, 1'b1, "gaps");
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b1, "gap err");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, "gap hold");
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, "gap err2");

        // Asynchronous reset while locked with bit_err high, no clock edge
        rst = 1'b1;
        #2;
        check("async locked",  32'(bus.locked),  32'd0);
        check("async bit_err", 32'(bus.bit_err), 32'd0);
        check("async err_cnt", 32'(bus.err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        gen = SEED;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, "post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
        $finish;
    end

endmodule
